// File: rtl/level_sequencer.sv
// Difficulty scheduler: tracks hits, misses and lives, advances the level and drives block size.
// Optional LEVEL_WRAP_EN: a level advance at level 7 wraps to level 0 instead of saturating.
module level_sequencer #(
  parameter int HITS_PER_LEVEL = 8,
  parameter int LIVES_INIT     = 3,
  parameter int FLASH_CYCLES   = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       manual,
  input  logic [2:0] sw_level,
  output logic [2:0] level,
  output logic [8:0] size,
  output logic [1:0] lives,
  output logic       level_up,
  output logic       playing,
  output logic       game_over
);

  localparam int HCW = $clog2(HITS_PER_LEVEL);
  localparam int FCW = $clog2(FLASH_CYCLES + 1);
  localparam logic [HCW-1:0] HIT_LAST   = HCW'(HITS_PER_LEVEL - 1);
  localparam logic [FCW-1:0] FLASH_LOAD = FCW'(FLASH_CYCLES - 1);
  localparam logic [1:0]     LIVES_LOAD = 2'(LIVES_INIT);

`ifdef LEVEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

  state_t         state, state_next;
  logic [HCW-1:0] hit_cnt, hit_next;
  logic [FCW-1:0] flash_cnt, flash_next;
  logic [2:0]     level_next;
  logic [1:0]     lives_next;
  logic [8:0]     size_next;
  logic           level_up_next, playing_next, game_over_next;

  function automatic logic [8:0] size_of(input logic [2:0] lv);
    case (lv)
      3'd0:    size_of = 9'd30;
      3'd1:    size_of = 9'd60;
      3'd2:    size_of = 9'd120;
      3'd3:    size_of = 9'd150;
      3'd4:    size_of = 9'd180;
      3'd5:    size_of = 9'd210;
      3'd6:    size_of = 9'd240;
      default: size_of = 9'd250;
    endcase
  endfunction

  // State and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      level     <= 3'd0;
      size      <= 9'd30;
      lives     <= LIVES_LOAD;
      hit_cnt   <= '0;
      flash_cnt <= '0;
      level_up  <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      size      <= size_next;
      lives     <= lives_next;
      hit_cnt   <= hit_next;
      flash_cnt <= flash_next;
      level_up  <= level_up_next;
      playing   <= playing_next;
      game_over <= game_over_next;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_next    = state;
    level_next    = level;
    lives_next    = lives;
    hit_next      = hit_cnt;
    flash_next    = flash_cnt;
    level_up_next = 1'b0;
    case (state)
      IDLE: begin
        level_next = manual ? sw_level : 3'd0;
        if (start) begin
          state_next = PLAY;
          lives_next = LIVES_LOAD;
          hit_next   = '0;
        end
      end
      PLAY: begin
        if (miss) begin
          if (lives == 2'd1) begin
            lives_next = 2'd0;
            state_next = OVER;
          end else begin
            lives_next = lives - 2'd1;
          end
        end else if (hit) begin
          if (hit_cnt < HIT_LAST) begin
            hit_next = hit_cnt + HCW'(1);
          end else begin
            hit_next = '0;
            // Level 7 saturates silently unless wrapping is built in
            if (level != 3'd7 || WRAP) begin
              level_next    = level + 3'd1;
              level_up_next = 1'b1;
              state_next    = PAUSE;
              flash_next    = FLASH_LOAD;
            end
          end
        end
      end
      PAUSE: begin
        if (flash_cnt == '0) state_next = PLAY;
        else                 flash_next = flash_cnt - FCW'(1);
      end
      OVER: begin
        if (start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs derived from the upcoming state so they register alongside it
  always_comb begin
    playing_next   = (state_next == PLAY) || (state_next == PAUSE);
    game_over_next = (state_next == OVER);
    size_next      = size_of(level_next);
  end

endmodule
